// File: rtl/wisc_pkg.sv
// wisc_pkg: shared widths, ALU opcodes and ID/EX control bundle
package wisc_pkg;
  localparam int REG_W  = 4;
  localparam int DATA_W = 16;
  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_SLL = 4'h5,
    ALU_SRL = 4'h6,
    ALU_SRA = 4'h7,
    ALU_SLT = 4'h8,
    ALU_LUI = 4'h9
  } aluop_t;
  typedef struct packed {
    logic   regwrite;
    logic   memread;
    logic   memwrite;
    logic   memtoreg;
    logic   alusrc;
    aluop_t aluop;
  } id_ex_ctrl_t;
  localparam id_ex_ctrl_t BUBBLE_CTRL = '{regwrite: 1'b0, memread: 1'b0, memwrite: 1'b0,
                                          memtoreg: 1'b0, alusrc: 1'b0, aluop: ALU_ADD};
endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// id_ex_pipe_reg_if: decoded ID fields in, registered EX fields and stall status out
interface id_ex_pipe_reg_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int CNT_W  = 16
);
  logic [REG_W-1:0]  id_rs, id_rt, id_rd, ex_rs, ex_rt, ex_rd;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm, id_pc;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc;
  logic [3:0]        id_aluop, ex_aluop;
  logic              id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic              ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic              load_use_stall;
  logic [CNT_W-1:0]  stall_cnt;
  modport master (
    output id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_pc, id_aluop,
           id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg,
    input  ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm, ex_pc, ex_aluop,
           ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
           load_use_stall, stall_cnt
  );
  modport slave (
    input  id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_pc, id_aluop,
           id_alusrc, id_regwrite, id_memread, id_memwrite, id_memtoreg,
    output ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm, ex_pc, ex_aluop,
           ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
           load_use_stall, stall_cnt
  );
endinterface

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// load_use_detect: hazard between a load in EX and a consumer in ID; store data rt is forwarded
module load_use_detect #(
  parameter int REG_W = 4
) (
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_memwrite_i,
  output logic             hz_o
);
  assign hz_o = ex_memread_i & (ex_rd_i != '0) &
                ((ex_rd_i == id_rs_i) | ((ex_rd_i == id_rt_i) & ~id_memwrite_i));
endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX register with load-use bubble insertion, flush, hold and stall counting
module id_ex_pipe_reg #(
  parameter int DATA_W = wisc_pkg::DATA_W,
  parameter int REG_W  = wisc_pkg::REG_W,
  parameter int CNT_W  = 16
) (
  input logic        clk,
  input logic        rst_n,
  input logic        hold_in,
  input logic        flush_in,
  id_ex_pipe_reg_if.slave bus
);
  import wisc_pkg::*;
  typedef struct packed {
    logic [REG_W-1:0]  rs, rt, rd;
    logic [DATA_W-1:0] rs_data, rt_data, imm, pc;
    id_ex_ctrl_t       ctrl;
  } payload_t;
  payload_t id_d, ex_d, ex_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic hz;
  assign id_d = '{rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd,
                  rs_data: bus.id_rs_data, rt_data: bus.id_rt_data, imm: bus.id_imm, pc: bus.id_pc,
                  ctrl: '{regwrite: bus.id_regwrite, memread: bus.id_memread,
                          memwrite: bus.id_memwrite, memtoreg: bus.id_memtoreg,
                          alusrc: bus.id_alusrc, aluop: aluop_t'(bus.id_aluop)}};
  load_use_detect #(.REG_W(REG_W)) u_lud (
    .ex_memread_i (ex_q.ctrl.memread),
    .ex_rd_i      (ex_q.rd),
    .id_rs_i      (bus.id_rs),
    .id_rt_i      (bus.id_rt),
    .id_memwrite_i(bus.id_memwrite),
    .hz_o         (hz)
  );
  always_comb begin
    ex_d = id_d;
    if (flush_in | hz) begin
      ex_d = '0;
      ex_d.ctrl = BUBBLE_CTRL;
    end
    cnt_d = (hz & ~flush_in & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else if (!hold_in) begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  assign bus.load_use_stall = hz & ~flush_in & ~hold_in;
  assign bus.stall_cnt      = cnt_q;
  assign bus.ex_rs          = ex_q.rs;
  assign bus.ex_rt          = ex_q.rt;
  assign bus.ex_rd          = ex_q.rd;
  assign bus.ex_rs_data     = ex_q.rs_data;
  assign bus.ex_rt_data     = ex_q.rt_data;
  assign bus.ex_imm         = ex_q.imm;
  assign bus.ex_pc          = ex_q.pc;
  assign bus.ex_aluop       = ex_q.ctrl.aluop;
  assign bus.ex_alusrc      = ex_q.ctrl.alusrc;
  assign bus.ex_regwrite    = ex_q.ctrl.regwrite;
  assign bus.ex_memread     = ex_q.ctrl.memread;
  assign bus.ex_memwrite    = ex_q.ctrl.memwrite;
  assign bus.ex_memtoreg    = ex_q.ctrl.memtoreg;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed checks of pass-through, load-use, priority, reset and saturation
module tb_id_ex_pipe_reg;
  logic clk = 1'b0;
  logic rst_n, hold_in, flush_in;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  id_ex_pipe_reg_if #(.DATA_W(16), .REG_W(4), .CNT_W(16)) m ();
  id_ex_pipe_reg_if #(.DATA_W(16), .REG_W(4), .CNT_W(2))  s ();
  assign s.id_rs       = m.id_rs;
  assign s.id_rt       = m.id_rt;
  assign s.id_rd       = m.id_rd;
  assign s.id_rs_data  = m.id_rs_data;
  assign s.id_rt_data  = m.id_rt_data;
  assign s.id_imm      = m.id_imm;
  assign s.id_pc       = m.id_pc;
  assign s.id_aluop    = m.id_aluop;
  assign s.id_alusrc   = m.id_alusrc;
  assign s.id_regwrite = m.id_regwrite;
  assign s.id_memread  = m.id_memread;
  assign s.id_memwrite = m.id_memwrite;
  assign s.id_memtoreg = m.id_memtoreg;
  id_ex_pipe_reg #(.DATA_W(16), .REG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .hold_in(hold_in), .flush_in(flush_in), .bus(m));
  id_ex_pipe_reg #(.DATA_W(16), .REG_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .hold_in(hold_in), .flush_in(flush_in), .bus(s));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] rs, rt, rd, input logic mr, mw, rw);
    m.id_rs = rs;
    m.id_rt = rt;
    m.id_rd = rd;
    m.id_rs_data = {4{rs}};
    m.id_rt_data = {4{rt}};
    m.id_imm = 16'h0008;
    m.id_pc = 16'h0100;
    m.id_aluop = 4'h0;
    m.id_alusrc = mr | mw;
    m.id_regwrite = rw;
    m.id_memread = mr;
    m.id_memwrite = mw;
    m.id_memtoreg = mr;
  endtask
  initial begin
    rst_n = 1'b0;
    hold_in = 1'b0;
    flush_in = 1'b0;
    drive(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_ex_rd", m.ex_rd, 0);
    chk("rst_ex_regwrite", m.ex_regwrite, 0);
    chk("rst_stall_cnt", m.stall_cnt, 0);
    #3 rst_n = 1'b1;
    drive(4'd3, 4'd4, 4'd5, 1'b0, 1'b0, 1'b1);
    m.id_rs_data = 16'h1234;
    m.id_rt_data = 16'h5678;
    m.id_imm = 16'h0010;
    m.id_pc = 16'h0102;
    m.id_aluop = 4'h1;
    #1 chk("pass_no_stall", m.load_use_stall, 0);
    tick();
    chk("pass_ex_rs", m.ex_rs, 3);
    chk("pass_ex_rt", m.ex_rt, 4);
    chk("pass_ex_rd", m.ex_rd, 5);
    chk("pass_rs_data", m.ex_rs_data, 16'h1234);
    chk("pass_rt_data", m.ex_rt_data, 16'h5678);
    chk("pass_imm", m.ex_imm, 16'h0010);
    chk("pass_pc", m.ex_pc, 16'h0102);
    chk("pass_aluop", m.ex_aluop, 1);
    chk("pass_regwrite", m.ex_regwrite, 1);
    chk("pass_memread", m.ex_memread, 0);
    drive(4'd1, 4'd0, 4'd2, 1'b1, 1'b0, 1'b1);
    tick();
    chk("lw_ex_memread", m.ex_memread, 1);
    drive(4'd2, 4'd3, 4'd6, 1'b0, 1'b0, 1'b1);
    #1 chk("lu_stall", m.load_use_stall, 1);
    tick();
    chk("lu_bubble_rd", m.ex_rd, 0);
    chk("lu_bubble_rs", m.ex_rs, 0);
    chk("lu_bubble_regwrite", m.ex_regwrite, 0);
    chk("lu_bubble_memread", m.ex_memread, 0);
    chk("lu_cnt", m.stall_cnt, 1);
    chk("lu_stall_drops", m.load_use_stall, 0);
    tick();
    chk("lu_add_rd", m.ex_rd, 6);
    chk("lu_add_rs", m.ex_rs, 2);
    drive(4'd1, 4'd0, 4'd2, 1'b1, 1'b0, 1'b1);
    tick();
    drive(4'd7, 4'd2, 4'd0, 1'b0, 1'b1, 1'b0);
    #1 chk("sw_no_stall", m.load_use_stall, 0);
    tick();
    chk("sw_ex_memwrite", m.ex_memwrite, 1);
    chk("sw_ex_rt", m.ex_rt, 2);
    chk("sw_cnt", m.stall_cnt, 1);
    drive(4'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(4'd0, 4'd0, 4'd3, 1'b0, 1'b0, 1'b1);
    #1 chk("r0_no_stall", m.load_use_stall, 0);
    tick();
    chk("r0_ex_rd", m.ex_rd, 3);
    drive(4'd1, 4'd0, 4'd4, 1'b1, 1'b0, 1'b1);
    tick();
    drive(4'd4, 4'd0, 4'd5, 1'b0, 1'b0, 1'b1);
    flush_in = 1'b1;
    #1 chk("flush_no_stall", m.load_use_stall, 0);
    tick();
    chk("flush_bubble_rd", m.ex_rd, 0);
    chk("flush_bubble_regwrite", m.ex_regwrite, 0);
    chk("flush_cnt", m.stall_cnt, 1);
    flush_in = 1'b0;
    drive(4'd1, 4'd0, 4'd4, 1'b1, 1'b0, 1'b1);
    tick();
    drive(4'd4, 4'd0, 4'd7, 1'b0, 1'b0, 1'b1);
    hold_in = 1'b1;
    #1 chk("hold_no_stall", m.load_use_stall, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_ex_rd", m.ex_rd, 4);
      chk("hold_ex_memread", m.ex_memread, 1);
      chk("hold_cnt", m.stall_cnt, 1);
    end
    hold_in = 1'b0;
    #1 chk("unhold_stall", m.load_use_stall, 1);
    tick();
    chk("unhold_bubble_rd", m.ex_rd, 0);
    chk("unhold_cnt", m.stall_cnt, 2);
    tick();
    chk("unhold_add_rd", m.ex_rd, 7);
    for (int i = 0; i < 4; i++) begin
      drive(4'd1, 4'd0, 4'd2, 1'b1, 1'b0, 1'b1);
      tick();
      drive(4'd2, 4'd5, 4'd3, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
    end
    chk("sat_main_cnt", m.stall_cnt, 6);
    chk("sat_small_cnt", s.stall_cnt, 3);
    chk("pre_rst_ex_rd", m.ex_rd, 3);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ex_rd", m.ex_rd, 0);
    chk("arst_ex_rs", m.ex_rs, 0);
    chk("arst_ex_regwrite", m.ex_regwrite, 0);
    chk("arst_rs_data", m.ex_rs_data, 0);
    chk("arst_cnt", m.stall_cnt, 0);
    chk("arst_small_cnt", s.stall_cnt, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
